// File: rtl/lsu_pkg.sv
// Shared encodings and store-formatting helpers for the memory-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] LOAD_LB   = 3'b000;
  localparam logic [2:0] LOAD_LH   = 3'b001;
  localparam logic [2:0] LOAD_LW   = 3'b010;
  localparam logic [2:0] LOAD_LBU  = 3'b100;
  localparam logic [2:0] LOAD_LHU  = 3'b101;
  localparam logic [2:0] LOAD_NONE = 3'b111;

  localparam logic [1:0] STORE_SB   = 2'b00;
  localparam logic [1:0] STORE_SH   = 2'b01;
  localparam logic [1:0] STORE_SW   = 2'b10;
  localparam logic [1:0] STORE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // Halfword enables follow addr[1] only, so an odd halfword offset lands on its aligned lane.
  function automatic logic [3:0] store_be(input logic [1:0] store_type, input logic [1:0] off);
    logic [3:0] be;
    case (store_type)
      STORE_SB: be = 4'b0001 << off;
      STORE_SH: be = off[1] ? 4'b1100 : 4'b0011;
      STORE_SW: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] store_type, input logic [31:0] rs2);
    logic [31:0] wdata;
    case (store_type)
      STORE_SB: wdata = {4{rs2[7:0]}};
      STORE_SH: wdata = {2{rs2[15:0]}};
      STORE_SW: wdata = rs2;
      default:  wdata = 32'h0000_0000;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_format.sv
// Selects the byte/halfword lane of a bus read word and sign- or zero-extends it.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    case (off_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (load_type_i)
      LOAD_LB:  data_o = {{24{byte_s[7]}}, byte_s};
      LOAD_LH:  data_o = {{16{half_s[15]}}, half_s};
      LOAD_LW:  data_o = rdata_i;
      LOAD_LBU: data_o = {24'h00_0000, byte_s};
      LOAD_LHU: data_o = {16'h0000, half_s};
      default:  data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM controls -> req/ack data-bus transaction.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic        mem_memory_write,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [1:0]  mem_memory_store_type,
  input  logic        mem_wb_load,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        bus_error,
  output logic        misalign,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             bus_error_q, bus_error_d;
  logic             misalign_q, misalign_d;
  logic [2:0]       ld_type_q, ld_type_d;
  logic [1:0]       off_q, off_d;

  logic        is_store_s;
  logic        is_load_s;
  logic        access_s;
  logic        misalign_s;
  logic [31:0] fmt_s;

  assign is_store_s = mem_memory_write & (mem_memory_store_type != STORE_NONE);
  assign is_load_s  = mem_wb_load & (mem_memory_load_type != LOAD_NONE);
  assign access_s   = is_store_s | is_load_s;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign_s = 1'b0;
    if (is_store_s) begin
      case (mem_memory_store_type)
        STORE_SH: misalign_s = mem_result[0];
        STORE_SW: misalign_s = (mem_result[1:0] != 2'b00);
        default:  misalign_s = 1'b0;
      endcase
    end else if (is_load_s) begin
      case (mem_memory_load_type)
        LOAD_LH, LOAD_LHU: misalign_s = mem_result[0];
        LOAD_LW:           misalign_s = (mem_result[1:0] != 2'b00);
        default:           misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  assign misalign_s = 1'b0;
`endif

  lsu_load_format u_load_format (
    .rdata_i     (dbus_rdata),
    .off_i       (off_q),
    .load_type_i (ld_type_q),
    .data_o      (fmt_s)
  );

  // Stall is combinational so the hazard unit freezes the pipe in the very cycle an access appears.
  assign mem_stall = ~rst & (((state_q == IDLE) & access_s) | (state_q == REQ));

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_error_d = 1'b0;
    misalign_d  = 1'b0;
    ld_type_d   = ld_type_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (access_s && misalign_s) begin
          state_d     = DONE;
          misalign_d  = 1'b1;
          load_data_d = 32'h0000_0000;
        end else if (access_s) begin
          state_d   = REQ;
          req_d     = 1'b1;
          we_d      = is_store_s;
          addr_d    = {mem_result[31:2], 2'b00};
          wdata_d   = is_store_s ? store_wdata(mem_memory_store_type, mem_op2_selected) : 32'h0000_0000;
          be_d      = is_store_s ? store_be(mem_memory_store_type, mem_result[1:0]) : 4'b0000;
          cnt_d     = '0;
          ld_type_d = is_store_s ? LOAD_NONE : mem_memory_load_type;
          off_d     = mem_result[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack arriving on the timeout cycle still completes the access normally.
        if (dbus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            load_data_d = fmt_s;
          end else begin
            load_data_d = load_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          load_data_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
      cnt_q       <= '0;
      load_data_q <= 32'h0000_0000;
      bus_error_q <= 1'b0;
      misalign_q  <= 1'b0;
      ld_type_q   <= LOAD_NONE;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_error_q <= bus_error_d;
      misalign_q  <= misalign_d;
      ld_type_q   <= ld_type_d;
      off_q       <= off_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
  assign dbus_be    = be_q;
  assign load_data  = load_data_q;
  assign bus_error  = bus_error_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, timeout, reset abort, misalignment.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_result;
  logic [31:0] mem_op2_selected;
  logic        mem_memory_write;
  logic [2:0]  mem_memory_load_type;
  logic [1:0]  mem_memory_store_type;
  logic        mem_wb_load;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        bus_error;
  logic        misalign;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int vectors = 0;
  int miscompares = 0;
  int stall_n;
  int req_n;
  logic        snap_we;
  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic [3:0]  snap_be;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .mem_result            (mem_result),
    .mem_op2_selected      (mem_op2_selected),
    .mem_memory_write      (mem_memory_write),
    .mem_memory_load_type  (mem_memory_load_type),
    .mem_memory_store_type (mem_memory_store_type),
    .mem_wb_load           (mem_wb_load),
    .mem_stall             (mem_stall),
    .load_data             (load_data),
    .bus_error             (bus_error),
    .misalign              (misalign),
    .dbus_req              (dbus_req),
    .dbus_we               (dbus_we),
    .dbus_addr             (dbus_addr),
    .dbus_wdata            (dbus_wdata),
    .dbus_be               (dbus_be),
    .dbus_ack              (dbus_ack),
    .dbus_rdata            (dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic wr, input logic [1:0] st, input logic ld,
                           input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] rs2);
    mem_memory_write      = wr;
    mem_memory_store_type = st;
    mem_wb_load           = ld;
    mem_memory_load_type  = lt;
    mem_result            = addr;
    mem_op2_selected      = rs2;
  endtask

  // New instruction enters MEM just after a clock edge; counts stall/req cycles and
  // acks after 'waits' extra REQ cycles (waits < 0: never ack). Ends in the DONE cycle.
  task automatic issue(input logic wr, input logic [1:0] st, input logic ld, input logic [2:0] lt,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int waits, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    set_instr(wr, st, ld, lt, addr, rs2);
    @(negedge clk);
    stall_n = 0;
    req_n   = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_stall !== 1'b1) break;
      stall_n++;
      if (dbus_req === 1'b1) begin
        req_n++;
        snap_we    = dbus_we;
        snap_addr  = dbus_addr;
        snap_wdata = dbus_wdata;
        snap_be    = dbus_be;
        if (waits >= 0 && req_n == waits + 1) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rdata;
        end
      end
      @(negedge clk);
      dbus_ack = 1'b0;
    end
    chk("stall_bounded", 32'(mem_stall), 32'd0);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    set_instr(1'b0, STORE_NONE, 1'b0, LOAD_NONE, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_req", 32'(dbus_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    set_instr(1'b0, STORE_NONE, 1'b0, LOAD_NONE, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_we", 32'(dbus_we), 32'd0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    rst = 1'b0;

    // SW, ack in first REQ cycle
    issue(1'b1, STORE_SW, 1'b0, LOAD_NONE, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0);
    chk("sw_stall", 32'(stall_n), 32'd2);
    chk("sw_reqs", 32'(req_n), 32'd1);
    chk("sw_we", 32'(snap_we), 32'd1);
    chk("sw_addr", snap_addr, 32'h0000_0100);
    chk("sw_be", 32'(snap_be), 32'hF);
    chk("sw_wdata", snap_wdata, 32'hDEAD_BEEF);
    chk("sw_req_done", 32'(dbus_req), 32'd0);
    chk("sw_load_data", load_data, 32'h0);

    // LB back-to-back after the store, three wait cycles
    issue(1'b0, STORE_NONE, 1'b1, LOAD_LB, 32'h0000_0203, 32'h0, 3, 32'h8011_2233);
    chk("lb_stall", 32'(stall_n), 32'd5);
    chk("lb_reqs", 32'(req_n), 32'd4);
    chk("lb_we", 32'(snap_we), 32'd0);
    chk("lb_be", 32'(snap_be), 32'd0);
    chk("lb_addr", snap_addr, 32'h0000_0200);
    chk("lb_data", load_data, 32'hFFFF_FF80);

    issue(1'b0, STORE_NONE, 1'b1, LOAD_LBU, 32'h0000_0203, 32'h0, 3, 32'h8011_2233);
    chk("lbu_stall", 32'(stall_n), 32'd5);
    chk("lbu_data", load_data, 32'h0000_0080);

    issue(1'b1, STORE_SH, 1'b0, LOAD_NONE, 32'h0000_0302, 32'h0000_ABCD, 0, 32'h0);
    chk("sh_be", 32'(snap_be), 32'hC);
    chk("sh_wdata", snap_wdata, 32'hABCD_ABCD);
    chk("sh_keeps_load_data", load_data, 32'h0000_0080);

    issue(1'b0, STORE_NONE, 1'b1, LOAD_LHU, 32'h0000_0302, 32'h0, 0, 32'h9876_5432);
    chk("lhu_data", load_data, 32'h0000_9876);

    issue(1'b0, STORE_NONE, 1'b1, LOAD_LH, 32'h0000_0300, 32'h0, 1, 32'h1234_8001);
    chk("lh_stall", 32'(stall_n), 32'd3);
    chk("lh_data", load_data, 32'hFFFF_8001);

    issue(1'b1, STORE_SB, 1'b0, LOAD_NONE, 32'h0000_0101, 32'h0000_0055, 0, 32'h0);
    chk("sb_be", 32'(snap_be), 32'h2);
    chk("sb_wdata", snap_wdata, 32'h5555_5555);
    chk("sb_addr", snap_addr, 32'h0000_0100);

    // Both flags set: store wins
    issue(1'b1, STORE_SW, 1'b1, LOAD_LW, 32'h0000_0104, 32'h0102_0304, 0, 32'hFFFF_FFFF);
    chk("both_we", 32'(snap_we), 32'd1);
    chk("both_load_data", load_data, 32'hFFFF_8001);

    // No ack: timeout after 16 REQ cycles
    issue(1'b0, STORE_NONE, 1'b1, LOAD_LW, 32'h0000_0400, 32'h0, -1, 32'h0);
    chk("to_stall", 32'(stall_n), 32'd17);
    chk("to_reqs", 32'(req_n), 32'd16);
    chk("to_bus_error", 32'(bus_error), 32'd1);
    chk("to_load_data", load_data, 32'h0);
    chk("to_req_done", 32'(dbus_req), 32'd0);
    go_idle();
    chk("to_bus_error_pulse", 32'(bus_error), 32'd0);

    // Reset mid-REQ, then a late ack
    @(posedge clk);
    #1;
    set_instr(1'b0, STORE_NONE, 1'b1, LOAD_LW, 32'h0000_0500, 32'h0);
    @(negedge clk);
    chk("rr_idle_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    chk("rr_req", 32'(dbus_req), 32'd1);
    #2;
    rst = 1'b1;
    set_instr(1'b0, STORE_NONE, 1'b0, LOAD_NONE, 32'h0, 32'h0);
    #1;
    chk("rr_req_drop", 32'(dbus_req), 32'd0);
    chk("rr_stall_drop", 32'(mem_stall), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h7777_7777;
    @(negedge clk);
    dbus_ack = 1'b0;
    chk("rr_late_ack_req", 32'(dbus_req), 32'd0);
    chk("rr_late_ack_stall", 32'(mem_stall), 32'd0);
    chk("rr_late_ack_data", load_data, 32'h0);
    chk("rr_late_ack_err", 32'(bus_error), 32'd0);

    issue(1'b0, STORE_NONE, 1'b1, LOAD_LW, 32'h0000_0600, 32'h0, 0, 32'hCAFE_F00D);
    chk("lw_stall", 32'(stall_n), 32'd2);
    chk("lw_data", load_data, 32'hCAFE_F00D);

    // Misaligned LW
    issue(1'b0, STORE_NONE, 1'b1, LOAD_LW, 32'h0000_0101, 32'h0, 0, 32'h1122_3344);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_stall", 32'(stall_n), 32'd1);
    chk("mis_reqs", 32'(req_n), 32'd0);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_load_data", load_data, 32'h0);
`else
    chk("mis_stall", 32'(stall_n), 32'd2);
    chk("mis_reqs", 32'(req_n), 32'd1);
    chk("mis_addr", snap_addr, 32'h0000_0100);
    chk("mis_pulse", 32'(misalign), 32'd0);
    chk("mis_load_data", load_data, 32'h1122_3344);
`endif
    go_idle();
    chk("end_misalign", 32'(misalign), 32'd0);
    chk("end_bus_error", 32'(bus_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
